i2c_reg_sequencer: RTL and testbench



---
 rtl/i2c_reg_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_i2c_reg_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer
// Turns one register-access request into the I2C byte engine's op sequence.
//   write      : START, WRITE {dev,0}, WRITE reg, WRITE data, STOP
//   burst read : START, WRITE {dev,0}, WRITE reg, START, WRITE {dev,1},
//                READ x rd_len, STOP
//   pointer set: START, WRITE {dev,0}, WRITE reg, STOP   (read, rd_len = 0)
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   start, rw, dev_addr,  request strobe and fields, latched in IDLE only
//   reg_addr, wr_data,
//   rd_len
//   busy, done            busy from the cycle after accept; done = 1-cycle pulse
//   rd_data, rd_valid     read byte stream, rd_data valid while rd_valid is high
//   i2c_instruction,      engine instruction (0 START, 1 STOP, 2 READ, 3 WRITE),
//   i2c_enable,           enable and byte to send
//   i2c_byte_out
//   i2c_byte_in,          engine received byte and completion flag
//   i2c_complete
//   error                 only with I2C_SEQ_TIMEOUT_EN: an engine op timed out
//   state_dbg             current handshake state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RELEASE)
//
// Handshake with the engine (one op):
//   ISSUE   : enable high, instruction/byte stable; wait for complete=0, since
//             complete is still high from the previous op until the engine
//             sees enable.
//   WAIT    : enable held; wait for complete=1.
//   RELEASE : enable low for exactly one cycle so the engine returns to idle.
//
// Optional feature macro: I2C_SEQ_TIMEOUT_EN adds the error output and a
// per-op cycle limit of TIMEOUT_CYCLES.
module i2c_reg_sequencer #(
  parameter int LEN_W = 4
`ifdef I2C_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       dev_addr,
  input  logic [7:0]       reg_addr,
  input  logic [7:0]       wr_data,
  input  logic [LEN_W-1:0] rd_len,
  output logic             busy,
  output logic             done,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [1:0]       i2c_instruction,
  output logic             i2c_enable,
  output logic [7:0]       i2c_byte_out,
  input  logic [7:0]       i2c_byte_in,
  input  logic             i2c_complete,
`ifdef I2C_SEQ_TIMEOUT_EN
  output logic             error,
`endif
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic [1:0] I_START = 2'd0;
  localparam logic [1:0] I_STOP  = 2'd1;
  localparam logic [1:0] I_READ  = 2'd2;
  localparam logic [1:0] I_WRITE = 2'd3;

  // Step counter values name the op being performed.
  localparam logic [2:0] OP_START  = 3'd0;
  localparam logic [2:0] OP_DEVW   = 3'd1;
  localparam logic [2:0] OP_REG    = 3'd2;
  localparam logic [2:0] OP_DATA   = 3'd3;
  localparam logic [2:0] OP_RSTART = 3'd4;
  localparam logic [2:0] OP_DEVR   = 3'd5;
  localparam logic [2:0] OP_READ   = 3'd6;
  localparam logic [2:0] OP_STOP   = 3'd7;

  logic [1:0]       state;
  logic [2:0]       step;
  logic [2:0]       next_step;
  logic [LEN_W-1:0] byte_cnt;
  logic             lat_rw;
  logic [6:0]       lat_dev;
  logic [7:0]       lat_reg;
  logic [7:0]       lat_data;
  logic [LEN_W-1:0] lat_len;
  logic [1:0]       op_instr;
  logic [7:0]       op_byte;
  logic             last_read;

  // Instruction and byte derive from registered step/fields only, so they
  // cannot change between ISSUE entry and WAIT exit.
  always_comb begin
    op_instr = I_START;
    op_byte  = 8'h00;
    case (step)
      OP_DEVW: begin op_instr = I_WRITE; op_byte = {lat_dev, 1'b0}; end
      OP_REG:  begin op_instr = I_WRITE; op_byte = lat_reg;         end
      OP_DATA: begin op_instr = I_WRITE; op_byte = lat_data;        end
      OP_DEVR: begin op_instr = I_WRITE; op_byte = {lat_dev, 1'b1}; end
      OP_READ: op_instr = I_READ;
      OP_STOP: op_instr = I_STOP;
      default: begin end
    endcase
  end

  // READ is only reached with lat_len > 0, so lat_len-1 never underflows there.
  assign last_read = (byte_cnt == (lat_len - LEN_W'(1)));

  always_comb begin
    next_step = step;
    case (step)
      OP_START:  next_step = OP_DEVW;
      OP_DEVW:   next_step = OP_REG;
      OP_REG: begin
        if (!lat_rw)              next_step = OP_DATA;
        else if (lat_len == '0)   next_step = OP_STOP;
        else                      next_step = OP_RSTART;
      end
      OP_DATA:   next_step = OP_STOP;
      OP_RSTART: next_step = OP_DEVR;
      OP_DEVR:   next_step = OP_READ;
      OP_READ:   next_step = last_read ? OP_STOP : OP_READ;
      default:   next_step = OP_START;
    endcase
  end

  assign i2c_instruction = op_instr;
  assign i2c_byte_out    = op_byte;
  assign i2c_enable      = (state == ST_ISSUE) || (state == ST_WAIT);
  assign state_dbg       = state;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  // Counts cycles spent in ISSUE+WAIT of the current op; it is zero on
  // every ISSUE entry because the preceding state is IDLE or RELEASE.
  always_ff @(posedge clk) begin
    if (reset)               tmo_cnt <= '0;
    else if (i2c_enable)     tmo_cnt <= tmo_cnt + TW'(1);
    else                     tmo_cnt <= '0;
  end

  assign tmo_hit = i2c_enable && (tmo_cnt == TMO_LAST);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      step     <= OP_START;
      byte_cnt <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      lat_rw   <= 1'b0;
      lat_dev  <= 7'h00;
      lat_reg  <= 8'h00;
      lat_data <= 8'h00;
      lat_len  <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      error    <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            lat_rw   <= rw;
            lat_dev  <= dev_addr;
            lat_reg  <= reg_addr;
            lat_data <= wr_data;
            lat_len  <= rd_len;
            step     <= OP_START;
            byte_cnt <= '0;
            busy     <= 1'b1;
            state    <= ST_ISSUE;
`ifdef I2C_SEQ_TIMEOUT_EN
            error    <= 1'b0;
`endif
          end
        end
        ST_ISSUE: begin
          if (!i2c_complete) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i2c_complete) begin
            // Capture here so rd_data/rd_valid are visible during RELEASE.
            if (step == OP_READ) begin
              rd_data  <= i2c_byte_in;
              rd_valid <= 1'b1;
            end
            state <= ST_RELEASE;
          end
        end
        default: begin // ST_RELEASE
          if (step == OP_READ) byte_cnt <= byte_cnt + LEN_W'(1);
          if (step == OP_STOP) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            step  <= OP_START;
            state <= ST_IDLE;
          end else begin
            step  <= next_step;
            state <= ST_ISSUE;
          end
        end
      endcase
`ifdef I2C_SEQ_TIMEOUT_EN
      // Abandon the transaction: enable drops with the return to IDLE.
      if (tmo_hit) begin
        error    <= 1'b1;
        done     <= 1'b1;
        busy     <= 1'b0;
        rd_valid <= 1'b0;
        step     <= OP_START;
        state    <= ST_IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Testbench for i2c_reg_sequencer with a behavioural I2C byte engine model.
module tb_i2c_reg_sequencer;

  localparam int LEN_W = 4;
  localparam logic [1:0] I_START = 2'd0;
  localparam logic [1:0] I_STOP  = 2'd1;
  localparam logic [1:0] I_READ  = 2'd2;
  localparam logic [1:0] I_WRITE = 2'd3;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             rw = 1'b0;
  logic [6:0]       dev_addr = 7'h00;
  logic [7:0]       reg_addr = 8'h00;
  logic [7:0]       wr_data = 8'h00;
  logic [LEN_W-1:0] rd_len = '0;
  logic             busy, done, rd_valid, i2c_enable;
  logic [7:0]       rd_data, i2c_byte_out;
  logic [1:0]       i2c_instruction, state_dbg;
  logic [7:0]       i2c_byte_in = 8'h00;
  logic             i2c_complete = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
  logic             error;
`endif

  always #5 clk = ~clk;

  i2c_reg_sequencer #(
    .LEN_W(LEN_W)
`ifdef I2C_SEQ_TIMEOUT_EN
    , .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data), .rd_len(rd_len),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
    .i2c_instruction(i2c_instruction), .i2c_enable(i2c_enable),
    .i2c_byte_out(i2c_byte_out), .i2c_byte_in(i2c_byte_in),
    .i2c_complete(i2c_complete),
`ifdef I2C_SEQ_TIMEOUT_EN
    .error(error),
`endif
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- engine model ----------------
  // Idle until enable seen (optionally holding the stale complete for
  // hold_cfg cycles), then complete=0 for lat_cfg+1 cycles, then complete=1
  // until enable drops.
  int        eng_st = 0;
  int        hold_cnt = 0;
  int        lat_cnt = 0;
  int        hold_cfg = 0;
  int        lat_cfg = 3;
  bit        never_complete = 1'b0;
  logic [1:0] cur_instr = 2'd0;
  logic [7:0] eng_rd_q[$];
  logic [9:0] got_ops[$];

  always @(posedge clk) begin
    case (eng_st)
      0: if (i2c_enable) begin
        if (hold_cnt < hold_cfg) hold_cnt <= hold_cnt + 1;
        else begin
          hold_cnt     <= 0;
          i2c_complete <= 1'b0;
          lat_cnt      <= lat_cfg;
          cur_instr    <= i2c_instruction;
          got_ops.push_back({i2c_instruction,
                             (i2c_instruction == I_WRITE) ? i2c_byte_out : 8'h00});
          eng_st       <= 1;
        end
      end
      1: if (!never_complete) begin
        if (lat_cnt == 0) begin
          i2c_complete <= 1'b1;
          if (cur_instr == I_READ)
            i2c_byte_in <= (eng_rd_q.size() > 0) ? eng_rd_q.pop_front() : 8'hEE;
          eng_st <= 2;
        end else lat_cnt <= lat_cnt - 1;
      end
      default: if (!i2c_enable) eng_st <= 0;
    endcase
  end

  // ---------------- output monitor ----------------
  logic [7:0] rd_got[$];
  int done_cnt = 0;
  int low_run = 0;
  int gap_err = 0;
  int en_hi_cnt = 0;

  always @(negedge clk) begin
    if (rd_valid) rd_got.push_back(rd_data);
    if (done) done_cnt++;
    if (i2c_enable) en_hi_cnt++;
    if (busy && !i2c_enable) low_run++;
    else if (i2c_enable) begin
      if (low_run > 1) gap_err++;
      low_run = 0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];
  logic [7:0] exp_rd[$];

  function automatic void build_ops(input logic r, input logic [6:0] d,
                                    input logic [7:0] ra, input logic [7:0] wd,
                                    input int l);
    exp_q.delete();
    exp_q.push_back({I_START, 8'h00});
    exp_q.push_back({I_WRITE, d, 1'b0});
    exp_q.push_back({I_WRITE, ra});
    if (!r) exp_q.push_back({I_WRITE, wd});
    else if (l > 0) begin
      exp_q.push_back({I_START, 8'h00});
      exp_q.push_back({I_WRITE, d, 1'b1});
      for (int i = 0; i < l; i++) exp_q.push_back({I_READ, 8'h00});
    end
    exp_q.push_back({I_STOP, 8'h00});
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    got_ops.delete();
    rd_got.delete();
    done_cnt = 0;
    low_run = 0;
    gap_err = 0;
  endtask

  // Leaves the caller at the negedge after the accepting posedge.
  task automatic pulse_start(input logic r, input logic [6:0] d, input logic [7:0] ra,
                             input logic [7:0] wd, input logic [LEN_W-1:0] l);
    @(negedge clk);
    start = 1'b1; rw = r; dev_addr = d; reg_addr = ra; wr_data = wd; rd_len = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      if (done) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    checks++; if (i2c_enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b want 0", i2c_enable); end
    checks++; if (i2c_instruction !== 2'd0) begin errors++; $display("FAIL reset_instr: got %0d want 0", i2c_instruction); end
    checks++; if (i2c_byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte_out: got %h want 00", i2c_byte_out); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
`ifdef I2C_SEQ_TIMEOUT_EN
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
`endif
  endtask

  task automatic test_write();
    clear_logs();
    build_ops(1'b0, 7'h57, 8'h09, 8'h03, 0);
    pulse_start(1'b0, 7'h57, 8'h09, 8'h03, '0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b want 1", busy); end
    wait_done();
    checks++; if (got_ops.size() !== exp_q.size()) begin errors++; $display("FAIL write_op_count: got %0d want %0d", got_ops.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_ops.size(); i++) begin
      checks++; if (got_ops[i] !== exp_q[i]) begin errors++; $display("FAIL write_op[%0d]: got %h want %h", i, got_ops[i], exp_q[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL write_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (rd_got.size() !== 0) begin errors++; $display("FAIL write_rd_valid: got %0d pulses want 0", rd_got.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_end: got %b want 0", busy); end
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL write_enable_gap: got %0d bad gaps want 0", gap_err); end
  endtask

  task automatic test_burst_read();
    clear_logs();
    eng_rd_q = '{8'h12, 8'h34, 8'h56};
    exp_rd   = '{8'h12, 8'h34, 8'h56};
    build_ops(1'b1, 7'h57, 8'h07, 8'h00, 3);
    pulse_start(1'b1, 7'h57, 8'h07, 8'h00, 4'd3);
    wait_done();
    checks++; if (got_ops.size() !== exp_q.size()) begin errors++; $display("FAIL burst_op_count: got %0d want %0d", got_ops.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_ops.size(); i++) begin
      checks++; if (got_ops[i] !== exp_q[i]) begin errors++; $display("FAIL burst_op[%0d]: got %h want %h", i, got_ops[i], exp_q[i]); end
    end
    checks++; if (rd_got.size() !== 3) begin errors++; $display("FAIL burst_rd_count: got %0d want 3", rd_got.size()); end
    for (int i = 0; i < exp_rd.size() && i < rd_got.size(); i++) begin
      checks++; if (rd_got[i] !== exp_rd[i]) begin errors++; $display("FAIL burst_rd[%0d]: got %h want %h", i, rd_got[i], exp_rd[i]); end
    end
    checks++; if (rd_data !== 8'h56) begin errors++; $display("FAIL burst_rd_data_last: got %h want 56", rd_data); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL burst_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_handshake();
    clear_logs();
    hold_cfg = 2;
    build_ops(1'b0, 7'h2A, 8'h10, 8'hC5, 0);
    pulse_start(1'b0, 7'h2A, 8'h10, 8'hC5, '0);
    // complete is still high from the previous op for these cycles.
    for (int i = 0; i < 3; i++) begin
      checks++; if (state_dbg !== 2'd1 || i2c_enable !== 1'b1) begin errors++; $display("FAIL hs_hold[%0d]: got state %0d en %b want state 1 en 1", i, state_dbg, i2c_enable); end
      @(negedge clk);
    end
    wait_done();
    hold_cfg = 0;
    checks++; if (got_ops.size() !== exp_q.size()) begin errors++; $display("FAIL hs_op_count: got %0d want %0d", got_ops.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_ops.size(); i++) begin
      checks++; if (got_ops[i] !== exp_q[i]) begin errors++; $display("FAIL hs_op[%0d]: got %h want %h", i, got_ops[i], exp_q[i]); end
    end
    checks++; if (gap_err !== 0) begin errors++; $display("FAIL hs_enable_gap: got %0d bad gaps want 0", gap_err); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL hs_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_pointer_only();
    clear_logs();
    build_ops(1'b1, 7'h57, 8'h20, 8'h00, 0);
    pulse_start(1'b1, 7'h57, 8'h20, 8'h00, 4'd0);
    wait_done();
    checks++; if (got_ops.size() !== 4) begin errors++; $display("FAIL ptr_op_count: got %0d want 4", got_ops.size()); end
    for (int i = 0; i < exp_q.size() && i < got_ops.size(); i++) begin
      checks++; if (got_ops[i] !== exp_q[i]) begin errors++; $display("FAIL ptr_op[%0d]: got %h want %h", i, got_ops[i], exp_q[i]); end
    end
    checks++; if (rd_got.size() !== 0) begin errors++; $display("FAIL ptr_rd_valid: got %0d pulses want 0", rd_got.size()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ptr_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_max_len();
    clear_logs();
    eng_rd_q.delete();
    exp_rd.delete();
    for (int i = 0; i < 15; i++) begin
      eng_rd_q.push_back(8'(i * 17 + 1));
      exp_rd.push_back(8'(i * 17 + 1));
    end
    build_ops(1'b1, 7'h3C, 8'hA0, 8'h00, 15);
    pulse_start(1'b1, 7'h3C, 8'hA0, 8'h00, 4'd15);
    wait_done();
    checks++; if (got_ops.size() !== 21) begin errors++; $display("FAIL max_op_count: got %0d want 21", got_ops.size()); end
    for (int i = 0; i < exp_q.size() && i < got_ops.size(); i++) begin
      checks++; if (got_ops[i] !== exp_q[i]) begin errors++; $display("FAIL max_op[%0d]: got %h want %h", i, got_ops[i], exp_q[i]); end
    end
    checks++; if (rd_got.size() !== 15) begin errors++; $display("FAIL max_rd_count: got %0d want 15", rd_got.size()); end
    for (int i = 0; i < exp_rd.size() && i < rd_got.size(); i++) begin
      checks++; if (rd_got[i] !== exp_rd[i]) begin errors++; $display("FAIL max_rd[%0d]: got %h want %h", i, rd_got[i], exp_rd[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL max_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_ignored();
    clear_logs();
    build_ops(1'b0, 7'h11, 8'h22, 8'h33, 0);
    pulse_start(1'b0, 7'h11, 8'h22, 8'h33, '0);
    repeat (4) @(negedge clk);
    pulse_start(1'b1, 7'h7F, 8'hFF, 8'hEE, 4'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy: got %b want 1", busy); end
    wait_done();
    checks++; if (got_ops.size() !== exp_q.size()) begin errors++; $display("FAIL ign_op_count: got %0d want %0d", got_ops.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_ops.size(); i++) begin
      checks++; if (got_ops[i] !== exp_q[i]) begin errors++; $display("FAIL ign_op[%0d]: got %h want %h", i, got_ops[i], exp_q[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (rd_got.size() !== 0) begin errors++; $display("FAIL ign_rd_valid: got %0d pulses want 0", rd_got.size()); end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    pulse_start(1'b0, 7'h44, 8'h55, 8'h66, '0);
    for (int i = 0; i < 500; i++) begin
      if (got_ops.size() >= 3) break;
      @(negedge clk);
    end
    checks++; if (got_ops.size() !== 3) begin errors++; $display("FAIL rst_third_op: got %0d ops want 3", got_ops.size()); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (i2c_enable !== 1'b0) begin errors++; $display("FAIL rst_enable: got %b want 0", i2c_enable); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
    repeat (20) @(negedge clk);
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", done_cnt); end
    clear_logs();
    build_ops(1'b0, 7'h19, 8'h2B, 8'h3D, 0);
    pulse_start(1'b0, 7'h19, 8'h2B, 8'h3D, '0);
    wait_done();
    checks++; if (got_ops.size() !== exp_q.size()) begin errors++; $display("FAIL rst_after_op_count: got %0d want %0d", got_ops.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_ops.size(); i++) begin
      checks++; if (got_ops[i] !== exp_q[i]) begin errors++; $display("FAIL rst_after_op[%0d]: got %h want %h", i, got_ops[i], exp_q[i]); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rst_after_done_cnt: got %0d want 1", done_cnt); end
  endtask

`ifdef I2C_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    clear_logs();
    never_complete = 1'b1;
    @(negedge clk);
    en_hi_cnt = 0;
    pulse_start(1'b0, 7'h57, 8'h09, 8'h03, '0);
    wait_done();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL tmo_error: got %b want 1", error); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL tmo_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (en_hi_cnt !== 64) begin errors++; $display("FAIL tmo_cycles: got %0d want 64", en_hi_cnt); end
    checks++; if (busy !== 1'b0 || i2c_enable !== 1'b0) begin errors++; $display("FAIL tmo_idle: got busy %b en %b want 0 0", busy, i2c_enable); end
    never_complete = 1'b0;
    repeat (10) @(negedge clk);
    clear_logs();
    build_ops(1'b0, 7'h57, 8'h09, 8'h03, 0);
    pulse_start(1'b0, 7'h57, 8'h09, 8'h03, '0);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL tmo_error_clear: got %b want 0", error); end
    wait_done();
    checks++; if (got_ops.size() !== exp_q.size()) begin errors++; $display("FAIL tmo_after_op_count: got %0d want %0d", got_ops.size(), exp_q.size()); end
    checks++; if (done_cnt !== 1 || error !== 1'b0) begin errors++; $display("FAIL tmo_after_done: got done %0d err %b want 1 0", done_cnt, error); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_write();
    test_burst_read();
    test_handshake();
    test_pointer_only();
    test_max_len();
    test_start_ignored();
    test_reset_mid();
`ifdef I2C_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
